// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Build option UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote of the samples at ticks M-1, M, M+1.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);
  localparam logic [BW-1:0]             BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                    r_state, w_state_next;
  logic                      r_sync1, r_sync2;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt, w_edge_cnt_next;
  logic [BW-1:0]             r_bit_cnt, w_bit_cnt_next;
  logic [PRESCALE_WIDTH-1:0] r_prescale, w_prescale_next;
  logic                      r_par_en, w_par_en_next;
  logic                      r_par_typ, w_par_typ_next;
  logic [DATA_WIDTH-1:0]     r_data, w_data_next;
  logic                      r_par_bad, w_par_bad_next;
  logic [DATA_WIDTH-1:0]     r_p_data, w_p_data_next;
  logic                      r_valid, w_valid_next;
  logic                      r_par_err, w_par_err_next;
  logic                      r_stp_err, w_stp_err_next;
  logic                      r_samp_m;

  logic                      w_rx_s;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic                      w_at_m, w_at_dec, w_at_last;
  logic                      w_bit_val;
  logic [PRESCALE_WIDTH-1:0] w_edge_inc;

  assign w_rx_s     = r_sync2;
  assign w_half     = r_prescale >> 1;
  assign w_at_m     = (r_edge_cnt == w_half);
  assign w_at_dec   = (r_edge_cnt == (w_half + PS_ONE));
  assign w_at_last  = (r_edge_cnt == (r_prescale - PS_ONE));
  assign w_edge_inc = w_at_last ? '0 : (r_edge_cnt + PS_ONE);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_samp_m <= 1'b1;
    end else if (w_at_m) begin
      r_samp_m <= w_rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_samp_m1;
  logic w_at_m1;

  assign w_at_m1 = (r_edge_cnt == (w_half - PS_ONE));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_samp_m1 <= 1'b1;
    end else if (w_at_m1) begin
      r_samp_m1 <= w_rx_s;
    end
  end

  // Third vote is the live sample at the decision tick M+1.
  assign w_bit_val = (r_samp_m1 & r_samp_m) | (r_samp_m1 & w_rx_s) | (r_samp_m & w_rx_s);
`else
  assign w_bit_val = r_samp_m;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_data     <= '0;
      r_par_bad  <= 1'b0;
      r_p_data   <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_edge_cnt <= w_edge_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_prescale <= w_prescale_next;
      r_par_en   <= w_par_en_next;
      r_par_typ  <= w_par_typ_next;
      r_data     <= w_data_next;
      r_par_bad  <= w_par_bad_next;
      r_p_data   <= w_p_data_next;
      r_valid    <= w_valid_next;
      r_par_err  <= w_par_err_next;
      r_stp_err  <= w_stp_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_edge_cnt_next = r_edge_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_prescale_next = r_prescale;
    w_par_en_next   = r_par_en;
    w_par_typ_next  = r_par_typ;
    w_data_next     = r_data;
    w_par_bad_next  = r_par_bad;
    w_p_data_next   = r_p_data;
    w_valid_next    = 1'b0;
    w_par_err_next  = 1'b0;
    w_stp_err_next  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_edge_cnt_next = '0;
        // The cycle that first sees the line low is tick 0 of the start bit.
        if (!w_rx_s) begin
          w_state_next    = S_START;
          w_edge_cnt_next = PS_ONE;
          w_bit_cnt_next  = '0;
          w_prescale_next = PRESCALE;
          w_par_en_next   = PAR_EN;
          w_par_typ_next  = PAR_TYP;
          w_par_bad_next  = 1'b0;
        end
      end

      S_START: begin
        w_edge_cnt_next = w_edge_inc;
        if (w_at_dec && w_bit_val) begin
          w_state_next    = S_IDLE;
          w_edge_cnt_next = '0;
        end else if (w_at_last) begin
          w_state_next = S_DATA;
        end
      end

      S_DATA: begin
        w_edge_cnt_next = w_edge_inc;
        if (w_at_dec) begin
          w_data_next[r_bit_cnt] = w_bit_val;
        end
        if (w_at_last) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_ONE;
          end
        end
      end

      S_PARITY: begin
        w_edge_cnt_next = w_edge_inc;
        if (w_at_dec) begin
          w_par_bad_next = w_bit_val ^ (^r_data) ^ r_par_typ;
        end
        if (w_at_last) begin
          w_state_next = S_STOP;
        end
      end

      S_STOP: begin
        w_edge_cnt_next = r_edge_cnt + PS_ONE;
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (w_at_dec) begin
          w_edge_cnt_next = '0;
          w_par_err_next  = r_par_bad;
          w_stp_err_next  = !w_bit_val;
          if (w_bit_val && !r_par_bad) begin
            w_valid_next  = 1'b1;
            w_p_data_next = r_data;
          end
          w_state_next = w_bit_val ? S_IDLE : S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        w_edge_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_edge_cnt_next = '0;
      end
    endcase
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences, and random frames
// checked against a frame-level reference model (outcome and strobe cycle per frame).
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK      = 1'b0;
  logic          RST      = 1'b1;
  logic          RX_IN    = 1'b1;
  logic [PW-1:0] PRESCALE = PW'(8);
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]   t;
    logic          v;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } ev_t;

  typedef struct {
    int            p;
    logic          pen;
    logic          ptyp;
    logic [DW-1:0] d;
    logic          flip;
    logic          stopv;
    logic          ev;
    logic          epe;
    logic          ese;
  } vec_t;

  ev_t           obs_q[$];
  ev_t           exp_q[$];
  logic [31:0]   cyc = 32'd0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] model_pdata = '0;

  always @(posedge CLK) cyc <= cyc + 32'd1;

  // Every cycle with any strobe high becomes one observed event.
  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR)
      obs_q.push_back({cyc, DATA_VALID, PAR_ERR, STP_ERR, P_DATA});
  end

  function automatic int legal_p();
    int r;
    r = int'($urandom_range(0, 2));
    return (r == 0) ? 8 : ((r == 1) ? 16 : 32);
  endfunction

  // Strobe lands (frame_bits-1)*P + P/2 + 4 edges after the start bit is driven.
  function automatic void push_exp(input logic [31:0] start, input int p, input logic pen,
                                   input logic v, input logic pe, input logic se,
                                   input logic [DW-1:0] d);
    int  fb;
    ev_t e;
    fb = DW + 2 + (pen ? 1 : 0);
    if (v) model_pdata = d;
    e = {start + 32'((fb - 1) * p + p / 2 + 4), v, pe, se, model_pdata};
    exp_q.push_back(e);
  endfunction

  function automatic void model_frame(input logic [31:0] start, input int p, input logic pen,
                                      input logic ptyp, input logic [DW-1:0] d, input logic flip,
                                      input logic stopv, input int glitch_bit);
    logic [DW-1:0] got;
    logic          pb;
    logic          pe;
    logic          se;
    got = d;
`ifndef UART_RX_MAJORITY_EN
    if (glitch_bit >= 0) got[glitch_bit] = ~got[glitch_bit];
`endif
    pb = (^d) ^ ptyp ^ flip;
    pe = pen && (pb != ((^got) ^ ptyp));
    se = !stopv;
    push_exp(start, p, pen, !pe && !se, pe, se, got);
  endfunction

  task automatic hold(input logic val, input int n, input int gl);
    for (int k = 0; k < n; k++) begin
      RX_IN = (k == gl) ? ~val : val;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    hold(1'b1, n, -1);
  endtask

  task automatic send_frame(input int p, input logic pen, input logic ptyp, input logic [DW-1:0] d,
                            input logic flip, input logic stopv, input int glitch_bit,
                            input logic scramble, output logic [31:0] start);
    logic pb;
    pb       = (^d) ^ ptyp ^ flip;
    PRESCALE = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    start    = cyc;
    hold(1'b0, p, -1);
    if (scramble) begin
      PRESCALE = PW'(legal_p());
      PAR_EN   = 1'($urandom_range(0, 1));
      PAR_TYP  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < DW; i++) hold(d[i], p, (i == glitch_bit) ? p / 2 : -1);
    if (pen) hold(pb, p, -1);
    hold(stopv, p, -1);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] %s ok: %h", tag, got);
    end
  endtask

  task automatic check_events(input string tag);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s strobe count: got %0d, expected %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      $display("[TB] %s strobe count ok: %0d", tag, obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s event %0d: got cyc=%0d v=%b pe=%b se=%b pd=%h, expected cyc=%0d v=%b pe=%b se=%b pd=%h",
                 tag, i, obs_q[i].t, obs_q[i].v, obs_q[i].pe, obs_q[i].se, obs_q[i].pd,
                 exp_q[i].t, exp_q[i].v, exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end else begin
        $display("[TB] %s event %0d ok: cyc=%0d v=%b pe=%b se=%b pd=%h",
                 tag, i, obs_q[i].t, obs_q[i].v, obs_q[i].pe, obs_q[i].se, obs_q[i].pd);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] s0;
    logic [31:0] s1;
    int          p;
    logic        pen;
    logic        ptyp;
    logic        flip;
    logic        stopv;
    logic [DW-1:0] d;

    vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_val("reset_p_data", 32'(P_DATA), 32'd0);
    check_val("reset_strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
    idle(4);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].d, vecs[i].flip, vecs[i].stopv,
                 -1, 1'b0, s0);
      push_exp(s0, vecs[i].p, vecs[i].pen, vecs[i].ev, vecs[i].epe, vecs[i].ese, vecs[i].d);
      idle(vecs[i].p + 4);
      check_events($sformatf("vec%0d", i));
    end

    // Back-to-back frames at PRESCALE=16, no parity.
    send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, s0);
    send_frame(16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1, 1'b0, s1);
    push_exp(s0, 16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    push_exp(s1, 16, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    idle(20);
    check_events("back_to_back");

    // Two-tick start glitch is rejected, then a clean frame follows.
    PRESCALE = PW'(8);
    PAR_EN   = 1'b0;
    hold(1'b0, 2, -1);
    idle(12);
    check_events("start_glitch");
    send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, 1'b0, s0);
    push_exp(s0, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    idle(12);
    check_events("after_glitch");

    // Stop bit low with the line stuck low: one error, nothing more until the line recovers.
    send_frame(8, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, -1, 1'b0, s0);
    hold(1'b0, 40, -1);
    push_exp(s0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66);
    idle(8);
    check_events("stuck_low");
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0, s0);
    push_exp(s0, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
    idle(12);
    check_events("after_stuck_low");

    // Reset pulse in the middle of data bit 4 of a 0xF0 frame.
    PRESCALE = PW'(8);
    PAR_EN   = 1'b0;
    hold(1'b0, 8 + 4 * 8, -1);
    hold(1'b1, 3, -1);
    RST = 1'b1;
    #1;
    check_val("mid_reset_p_data", 32'(P_DATA), 32'd0);
    check_val("mid_reset_strobes", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_pdata = '0;
    idle(100);
    check_events("mid_reset");
    send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, 1'b0, s0);
    push_exp(s0, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12);
    idle(12);
    check_events("after_reset");

    // One-tick flip at mid-bit of data bit 2.
    send_frame(16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2, 1'b0, s0);
    model_frame(s0, 16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 2);
    idle(20);
    check_events("mid_bit_glitch");

    // Random frames with config scrambled after the start bit.
    for (int n = 0; n < 24; n++) begin
      p     = legal_p();
      pen   = 1'($urandom_range(0, 1));
      ptyp  = 1'($urandom_range(0, 1));
      d     = DW'($urandom);
      flip  = ($urandom_range(0, 4) == 0);
      stopv = ($urandom_range(0, 4) != 0);
      send_frame(p, pen, ptyp, d, flip, stopv, -1, 1'b1, s0);
      model_frame(s0, p, pen, ptyp, d, flip, stopv, -1);
      if (!stopv) begin
        hold(1'b0, int'($urandom_range(0, 20)), -1);
        idle(p + 2);
      end else begin
        idle(int'($urandom_range(0, p)));
      end
    end
    idle(80);
    check_events("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
